mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file.
- Consumes read_data1 (rs) and read_data2 (rt) as operands for MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers, which are read by MFHI/MFLO muxing in writeback.
- One radix-2 iteration per clock: shift-add for multiply, restoring shift-subtract for divide. Start/busy/done handshake toward the control unit.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported.
- CNT_W, 5, iteration counter width. Must satisfy 2**CNT_W == DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  32  multiplicand / dividend (register file read_data1)
- rt_data  in  32  multiplier / divisor (register file read_data2)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; HI/LO valid from this cycle
- div_by_zero  out  1  one-cycle pulse coincident with done
- hi  out  32  HI register: product[63:32] or remainder
- lo  out  32  LO register: product[31:0] or quotient

Behaviour:
- Reset (asynchronous, any state): state=IDLE; hi=0, lo=0; busy=0, done=0, div_by_zero=0; counter=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE: on start=1 at edge N:
  - Latch op, and the magnitudes of rs_data/rt_data. Signed ops take two's-complement abs; unsigned ops take the raw value.
  - Record the result sign: XOR of the operand signs for the quotient/product, the dividend sign for the remainder.
  - Clear the counter and go to RUN.
  - Exception: DIV/DIVU with rt_data==0 goes straight to DONE.
- RUN: one iteration per edge. The counter increments 0..31; after the iteration with counter==31, go to FIX. RUN occupies edges N+1..N+32.
- FIX (edge N+33):
  - Apply sign correction by negating the 64-bit product, quotient or remainder as recorded.
  - Write hi/lo, then go to DONE.
- DONE (one cycle): done=1; div_by_zero=1 only on the divide-by-zero path. Return to IDLE on the next edge.
- busy=1 in RUN, FIX and DONE; 0 in IDLE.
- Latency:
  - Normal operation: start sampled at edge N gives done high in the cycle after edge N+34, i.e. 35 cycles from the start edge.
  - Divide by zero: done high in the cycle after edge N+1.
- Divide by zero: hi and lo are left unchanged.
- start while busy=1: ignored, with no effect on the in-flight operation.
- A new start may be sampled in the first IDLE cycle after DONE.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag.
- Multiply: full 64-bit product, with no overflow indication.
- Arithmetic widths:
  - Divide: 33-bit partial remainder for the trial subtract.
  - Multiply: 64-bit accumulator, formed as a 33-bit add on the upper half, then a right shift.
- rs_data/rt_data may change after the start edge without affecting the result.
- hi/lo change only at the FIX edge or on reset.

Decomposition:
- Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding, DATA_W.
- One sub-module, mdu_step: a combinational single iteration. Inputs are the accumulator, the operand and an is_div select; outputs are the next accumulator and the quotient bit. It is instantiated once, and the top holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 35 cycles after the start edge; busy high throughout.
- MULT rs=0xFFFFFFFD (-3), rt=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 → lo=14, hi=2.
- With hi=0x11, lo=0x22 preloaded, DIVU 7/0 → done and div_by_zero pulse the cycle after edge N+1; hi/lo stay 0x11/0x22.
- Assert rst at RUN counter==10 → hi=lo=0 and busy=0 immediately (asynchronously). A start pulse during busy is ignored, and the first result is unchanged.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned MDU_DATA_W = 32;
  localparam int unsigned MDU_CNT_W  = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [MDU_DATA_W-1:0] mag(input logic [MDU_DATA_W-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[MDU_DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// Single radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// One shared adder serves both operations; the quotient bit is merged by the caller.
module mdu_step
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_DATA_W
) (
  input  logic [2*DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0]   opnd_i,
  input  logic                is_div_i,
  output logic [2*DATA_W-1:0] acc_o,
  output logic                qbit_o
);

  logic [DATA_W-1:0] upper;
  logic [DATA_W-1:0] lower;
  logic [DATA_W+1:0] add_a;
  logic [DATA_W+1:0] add_b;
  logic [DATA_W+1:0] add_c;
  logic [DATA_W+1:0] sum;

  // Form adder operands, add, then shift the accumulator one place.
  always_comb begin
    upper  = acc_i[2*DATA_W-1:DATA_W];
    lower  = acc_i[DATA_W-1:0];
    add_a  = '0;
    add_b  = '0;
    add_c  = '0;
    qbit_o = 1'b0;
    acc_o  = acc_i;
    if (is_div_i) begin
      // 33-bit partial remainder minus divisor; bit DATA_W+1 is the borrow.
      add_a = {1'b0, upper, lower[DATA_W-1]};
      add_b = ~{2'b00, opnd_i};
      add_c = {{(DATA_W+1){1'b0}}, 1'b1};
    end else begin
      add_a = {2'b00, upper};
      add_b = lower[0] ? {2'b00, opnd_i} : '0;
    end
    sum = add_a + add_b + add_c;
    if (is_div_i) begin
      qbit_o = ~sum[DATA_W+1];
      acc_o  = {(qbit_o ? sum[DATA_W-1:0] : add_a[DATA_W-1:0]),
                lower[DATA_W-2:0], 1'b0};
    end else begin
      acc_o  = {sum[DATA_W:0], lower[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_DATA_W,
  parameter int unsigned CNT_W  = MDU_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  mdu_state_e state_q, state_d;

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  mdu_op_e             op_in;
  logic                in_signed;
  logic                in_div;
  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [2*DATA_W-1:0] step_acc;
  logic                step_qbit;
  logic [2*DATA_W-1:0] prod;

  assign op_in     = mdu_op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign rs_mag    = mag(rs_data, in_signed);
  assign rt_mag    = mag(rt_data, in_signed);

  mdu_step #(.DATA_W(DATA_W)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc),
    .qbit_o   (step_qbit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a zero divisor skips the iterations entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (in_div && (rt_data == '0)) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == '1) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand capture, iteration, sign fix-up into HI/LO.
  always_comb begin
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod      = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d  = in_div;
          neg_res_d = in_signed & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
          neg_rem_d = in_signed & rs_data[DATA_W-1];
          dz_d      = in_div && (rt_data == '0);
          cnt_d     = '0;
          if (in_div) begin
            acc_d  = {{DATA_W{1'b0}}, rs_mag};
            opnd_d = rt_mag;
          end else begin
            acc_d  = {{DATA_W{1'b0}}, rt_mag};
            opnd_d = rs_mag;
          end
        end
      end
      ST_RUN: begin
        acc_d = {step_acc[2*DATA_W-1:1], step_acc[0] | step_qbit};
        cnt_d = cnt_q + 1'b1;
      end
      ST_FIX: begin
        if (is_div_q) begin
          lo_d = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          hi_d = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        end else begin
          prod = neg_res_q ? -acc_q : acc_q;
          hi_d = prod[2*DATA_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
      end
      default: ;
    endcase
    // The completion pulses are registered off the DONE state, so they
    // appear one cycle after it.
    done_d = (state_q == ST_DONE);
    dbz_d  = (state_q == ST_DONE) && dz_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a cycle-level behavioural model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mult_div_unit #(.DATA_W(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    r  = '0;
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = ua * ub;
      2'b10: if (b != 0) begin sq = sa / sb; sr = sa % sb; r = {sr[31:0], sq[31:0]}; end
      default: if (b != 0) begin uq = ua / ub; ur = ua % ub; r = {ur[31:0], uq[31:0]}; end
    endcase
    return r;
  endfunction

  // Model: age = clock edges since the accepted start edge.
  bit          m_active = 1'b0;
  bit          m_dz = 1'b0;
  bit          m_prev_busy;
  int          m_age = 0;
  int          m_len = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_age = 0; m_len = 0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0;
    end else begin
      m_prev_busy = m_active && (m_age < m_len);
      if (m_active) m_age++;
      if (m_active && !m_dz && m_age == 33) begin
        m_hi = m_res_hi;
        m_lo = m_res_lo;
      end
      if (!m_prev_busy && start) begin
        {m_res_hi, m_res_lo} = ref_result(op, rs_data, rt_data);
        m_dz     = op[1] && (rt_data == 32'd0);
        m_len    = m_dz ? 1 : 34;
        m_age    = 0;
        m_active = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 64'(busy), 64'(m_active && m_age < m_len));
      check("done", 64'(done), 64'(m_active && m_age == m_len));
      check("div_by_zero", 64'(div_by_zero), 64'(m_active && m_age == m_len && m_dz));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Directed operation with literal expectations; optional start pulse mid-flight.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat, input bit exp_dz,
                        input bit poke);
    int lat, busy_gap;
    bit seen, dz_seen;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    lat = 0; busy_gap = 0; seen = 1'b0; dz_seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (poke && c == 5) begin
        start = 1'b1; op = 2'b00; rs_data = 32'h0000_1234; rt_data = 32'h0000_5678;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1; lat = c; dz_seen = div_by_zero;
      end else if (!busy) begin
        busy_gap++;
      end
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_gap"}, 64'(busy_gap), 64'd0);
    check({name, "_dbz"}, 64'(dz_seen), 64'(exp_dz));
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 35, 1'b0, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 35, 1'b0, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, 1'b0, 1'b0);
    run_op("divu_poke", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 35, 1'b0, 1'b1);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 35, 1'b0, 1'b0);
    run_op("preload",   2'b11, 32'h0000_0451, 32'h0000_0020, 32'h11, 32'h22, 35, 1'b0, 1'b0);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'h11, 32'h22, 2, 1'b1, 1'b0);

    // Asynchronous reset while RUN has counter==10.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_busy", 64'(busy), 64'd0);
    check("midrun_rst_hi", 64'(hi), 64'd0);
    check("midrun_rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 35, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) == 0);
      op      = 2'($urandom);
      rs_data = rand_word();
      rt_data = rand_word();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
